gc_event_rx: RTL and testbench

//  Single-clock receive end of a Gray-coded event-count crossing. Samples an asynchronous Gray

---
 rtl/gc_event_rx.sv | 79 +++++++
 tb/tb_gc_event_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gc_event_rx.sv
// gc_event_rx: Gray-count CDC receiver turning remote count advances into a handshaked event backlog (GC_EVENT_RX_GCCHK_EN adds Gray integrity checking)
module gc_event_rx #(
   parameter int CNTR_WIDTH    = 3,
   parameter int SYNC_STAGES   = 2,
   parameter int BACKLOG_WIDTH = 8
) (
   input  logic                     clk_out,
   input  logic                     resetn,
   input  logic [CNTR_WIDTH-1:0]    gc_in,
   output logic                     dout,
   input  logic                     dout_ready,
   output logic [BACKLOG_WIDTH-1:0] backlog,
   output logic                     overflow,
   output logic                     gc_err,
   input  logic                     err_clr
);
   typedef enum logic {ALIGN, RUN} state_t;
   localparam int AW = $clog2(SYNC_STAGES + 1);
   state_t state, state_nxt;
   logic [AW-1:0] align_cnt;
   logic [SYNC_STAGES-1:0][CNTR_WIDTH-1:0] sync_q;
   logic [CNTR_WIDTH-1:0] g_s, bin, bin_prev, delta;
   logic gc_bad, acc;
   logic [BACKLOG_WIDTH:0] sum;

   assign g_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      bin = '0;
      for (int i = 0; i < CNTR_WIDTH; i++) bin[i] = ^(g_s >> i);
   end

   always_ff @(posedge clk_out or negedge resetn)
      if (!resetn) begin
         state     <= ALIGN;
         align_cnt <= AW'(SYNC_STAGES);
      end else begin
         state <= state_nxt;
         if (state == ALIGN && align_cnt != '0) align_cnt <= align_cnt - AW'(1);
      end

   always_comb state_nxt = (state == ALIGN && align_cnt == '0) ? RUN : state;

`ifdef GC_EVENT_RX_GCCHK_EN
   logic [CNTR_WIDTH-1:0] g_s_prev, g_x;
   assign g_x    = g_s ^ g_s_prev;
   // more than one set bit <=> clearing the lowest set bit leaves something
   assign gc_bad = (state == RUN) && ((g_x & (g_x - CNTR_WIDTH'(1))) != '0);
   always_ff @(posedge clk_out or negedge resetn)
      if (!resetn) begin
         g_s_prev <= '0;
         gc_err   <= 1'b0;
      end else begin
         g_s_prev <= g_s;
         gc_err   <= gc_bad | (gc_err & ~err_clr);
      end
`else
   assign gc_bad = 1'b0;
   assign gc_err = 1'b0;
`endif

   assign delta = (state == RUN && !gc_bad) ? bin - bin_prev : '0;
   assign dout  = backlog != '0;
   assign acc   = dout && dout_ready;
   assign sum   = {1'b0, backlog} + (BACKLOG_WIDTH+1)'(delta) - (BACKLOG_WIDTH+1)'(acc);

   always_ff @(posedge clk_out or negedge resetn)
      if (!resetn) begin
         sync_q   <= '0;
         bin_prev <= '0;
         backlog  <= '0;
         overflow <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], gc_in};
         bin_prev <= bin;
         backlog  <= sum[BACKLOG_WIDTH] ? '1 : sum[BACKLOG_WIDTH-1:0];
         overflow <= sum[BACKLOG_WIDTH] | (overflow & ~err_clr);
      end
endmodule

// File: tb/tb_gc_event_rx.sv
// tb_gc_event_rx: table, directed and randomized checks of gc_event_rx against a count-level reference model
module tb_gc_event_rx;
   localparam int S = 2;
   logic       clk_out = 1'b0;
   logic       resetn = 1'b0;
   logic [2:0] gc_in = '0;
   logic       dout, dout_ready = 1'b0, overflow, gc_err, err_clr = 1'b0;
   logic [7:0] backlog;

   gc_event_rx dut (
      .clk_out(clk_out), .resetn(resetn), .gc_in(gc_in), .dout(dout),
      .dout_ready(dout_ready), .backlog(backlog), .overflow(overflow),
      .gc_err(gc_err), .err_clr(err_clr)
   );

   always #5 clk_out = ~clk_out;

   int n_chk = 0, n_pass = 0;
   int m_bl = 0, m_edges = 0;
   logic m_ovf = 1'b0, m_err = 1'b0;
   logic [2:0] hist [0:S];

   typedef struct { logic [2:0] g; logic r; int bl; logic d; } vec_t;
   vec_t tv [5];

   function automatic logic [2:0] gray(int n);
      logic [2:0] b;
      b = 3'(n);
      return b ^ (b >> 1);
   endfunction

   function automatic int g2b(logic [2:0] g);
      for (int n = 0; n < 8; n++) if (gray(n) == g) return n;
      return 0;
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // remote count seen S edges late; events = count advances, capped at 255
   task automatic tick(input logic [2:0] g, input logic r, input logic c);
      logic acc, bad;
      int d, sum;
      gc_in = g; dout_ready = r; err_clr = c;
      acc = (m_bl != 0) && r;
      @(posedge clk_out);
      if (!resetn) begin
         m_bl = 0; m_ovf = 0; m_err = 0; m_edges = 0;
         for (int k = 0; k <= S; k++) hist[k] = '0;
      end else begin
         m_edges++;
         bad = 1'b0;
`ifdef GC_EVENT_RX_GCCHK_EN
         bad = m_edges > S + 1 && $countones(hist[S-1] ^ hist[S]) > 1;
`endif
         d = (m_edges <= S + 1 || bad) ? 0 : (g2b(hist[S-1]) - g2b(hist[S]) + 8) % 8;
         sum = m_bl + d - int'(acc);
         if (sum > 255) begin m_bl = 255; m_ovf = 1; end
         else begin m_bl = sum; if (c) m_ovf = 0; end
         if (bad) m_err = 1; else if (c) m_err = 0;
         for (int k = S; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = g;
      end
      #1;
      chk("cyc_backlog", backlog, m_bl);
      chk("cyc_dout", dout, int'(m_bl != 0));
      chk("cyc_overflow", overflow, m_ovf);
      chk("cyc_gc_err", gc_err, m_err);
   endtask

   task automatic do_reset(input logic [2:0] g);
      resetn = 1'b0;
      repeat (2) tick(g, 0, 0);
      resetn = 1'b1;
      repeat (4) tick(g, 0, 0);
   endtask

   initial begin
      int cnt, n_acc;
      for (int k = 0; k <= S; k++) hist[k] = '0;
      tv[0] = '{3'b001, 1'b1, 0, 1'b0};
      tv[1] = '{3'b001, 1'b1, 0, 1'b0};
      tv[2] = '{3'b001, 1'b1, 1, 1'b1};
      tv[3] = '{3'b001, 1'b1, 0, 1'b0};
      tv[4] = '{3'b001, 1'b1, 0, 1'b0};

      // nonzero count at reset release is not an event
      repeat (3) tick(3'b110, 0, 0);
      chk("rst_backlog", backlog, 0);
      chk("rst_dout", dout, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_gc_err", gc_err, 0);
      resetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(3'b110, 1, 0);
         chk("align_backlog", backlog, 0);
         chk("align_dout", dout, 0);
      end

      // single step, ready high: one-cycle dout pulse
      do_reset(3'b000);
      for (int i = 0; i < 5; i++) begin
         tick(tv[i].g, tv[i].r, 0);
         chk($sformatf("tv%0d_backlog", i), backlog, tv[i].bl);
         chk($sformatf("tv%0d_dout", i), dout, tv[i].d);
      end

      // five events accumulated with ready low, then drained
      do_reset(3'b000);
      for (int c = 0; c < 6; c++) repeat (4) tick(gray(c), 0, 0);
      repeat (3) tick(gray(5), 0, 0);
      chk("hold_backlog", backlog, 5);
      chk("hold_dout", dout, 1);
      n_acc = 0;
      for (int i = 0; i < 10; i++) begin
         if (dout) n_acc++;
         tick(gray(5), 1, 0);
      end
      chk("drain_accepts", n_acc, 5);
      chk("drain_backlog", backlog, 0);

      // wrap 7 -> 0 counts as one event
      do_reset(gray(4));
      for (int c = 5; c < 15; c++) repeat (2) tick(gray(c), 0, 0);
      repeat (3) tick(gray(14), 0, 0);
      chk("wrap_backlog", backlog, 10);
      chk("wrap_gc_err", gc_err, 0);

      // saturation, overflow flag and its clear
      do_reset(3'b000);
      for (int c = 1; c <= 260; c++) tick(gray(c), 0, 0);
      repeat (3) tick(gray(260), 0, 0);
      chk("sat_backlog", backlog, 255);
      chk("sat_overflow", overflow, 1);
      tick(gray(260), 0, 1);
      chk("clr_overflow", overflow, 0);
      chk("clr_backlog", backlog, 255);
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_backlog", backlog, 0);
      chk("async_rst_dout", dout, 0);
      tick(gray(260), 0, 0);

      // two-bit Gray jump 000 -> 010
      resetn = 1'b1;
      repeat (4) tick(3'b000, 0, 0);
      repeat (4) tick(3'b010, 0, 0);
`ifdef GC_EVENT_RX_GCCHK_EN
      chk("jump_gc_err", gc_err, 1);
      chk("jump_backlog", backlog, 0);
`else
      chk("jump_gc_err", gc_err, 0);
      chk("jump_backlog", backlog, 3);
`endif
      tick(3'b010, 0, 1);
      chk("jump_clr_gc_err", gc_err, 0);
      repeat (3) tick(3'b110, 0, 0);
`ifdef GC_EVENT_RX_GCCHK_EN
      chk("rebase_backlog", backlog, 1);
`else
      chk("rebase_backlog", backlog, 4);
`endif

      // randomized traffic with occasional jumps, clears and a mid-run reset
      do_reset(3'b000);
      cnt = 0;
      for (int i = 0; i < 600; i++) begin
         if (i == 300) resetn = 1'b0;
         if (i == 302) resetn = 1'b1;
         if ($urandom_range(15) == 0) cnt += $urandom_range(3, 2);
         else if ($urandom_range(1) == 1) cnt++;
         tick(gray(cnt % 8), $urandom_range(2) == 0, $urandom_range(7) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
